riscv_mc_controller: RTL and testbench
======================================

RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 Ports SHALL be exactly, in this order:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- op  in  7  instruction opcode (instr[6:0])
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write strobe
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUfunc  out  3  ALU operation select
- illegal  out  1  one-cycle pulse in DECODE for an unsupported op or funct3
- state  out  4  current state, debug only

Function
REQ-002 ALUfunc encoding SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sltu.
REQ-003 Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111.
REQ-004 The controller SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10. The only Mealy output SHALL be PCWrite in BRANCH.
REQ-005 Per-state outputs (unlisted strobes 0, unlisted selects 00):
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, add.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, decoded func.
- EXECI: ALUSrcA=10, ALUSrcB=01, decoded func.
- ALUWB: RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, compare func, PCWrite=take.
- JAL: ALUSrcA=01, ALUSrcB=10, add, PCWrite=1.
REQ-006 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR (lw/sw), EXECR, EXECI, BRANCH or JAL by op; any other op -> FETCH with illegal=1.
- MEMADR->MEMREAD (lw) / MEMWRITE (sw); MEMREAD->MEMWB.
- EXECR/EXECI->ALUWB; JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-007 Func decode: funct3 000 -> sub if (R-type and funct7b5) else add; 100 xor; 110 or; 111 and; 010 slt; 011 sltu. Funct3 001 or 101 on R/I-type SHALL drive illegal=1 in DECODE and return to FETCH.
REQ-008 Branch compare: beq (000) uses sub, take=zero.
REQ-009 ImmSrc SHALL be combinational from op, independent of state: lw/I-ALU 00, sw 01, branch 10, jal 11, others 00.
REQ-010 Instruction latency SHALL be: lw 5 cycles, sw/R/I/jal 4, branch 3.

Reset
REQ-011 With rst=1 at a clock edge, state SHALL become FETCH.
REQ-012 While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and illegal SHALL be forced to 0, overriding state decode.
REQ-013 Reset asserted mid-instruction SHALL abort it with no further strobe.

Configuration
REQ-014 BRANCH_EXT_EN defined: additionally decode bne (001, sub, take=~zero), blt (100, slt, take=~zero), bge (101, slt, take=zero), bltu (110, sltu, take=~zero), bgeu (111, sltu, take=zero). Undefined: branch op with funct3!=000 SHALL assert illegal in DECODE and return to FETCH.

Structure
REQ-015 Package riscv_mc_pkg SHALL hold the state encoding, ALUfunc codes, opcodes and mux select codes.
REQ-016 Combinational sub-module alu_decoder SHALL map (state class, op, funct3, funct7b5) to ALUfunc and the illegal flag.

Verification
REQ-017 Reset, then release -> state=0, IRWrite=1, PCWrite=1, ALUSrcB=10 in the first cycle.
REQ-018 lw sequence -> states 0,1,2,3,4 then 0; RegWrite=1 only in state 4 with ResultSrc=01.
REQ-019 R-type funct3=000 with funct7b5=1 -> EXECR ALUfunc=001; with funct7b5=0 -> 000; I-type funct7b5=1 -> 000.
REQ-020 beq: zero=1 -> PCWrite=1 in BRANCH; zero=0 -> PCWrite=0; each returns to FETCH after 3 cycles.
REQ-021 op=1111111 -> illegal=1 for one cycle in DECODE, then FETCH; no RegWrite or MemWrite asserted.
REQ-022 BRANCH_EXT_EN: bgeu with zero=1 -> ALUfunc=110, PCWrite=1. Without the macro: same instruction -> illegal=1.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: state encoding, ALU function codes, opcodes and mux selects for the multicycle controller
package riscv_mc_pkg;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL
  } state_t;
  typedef enum logic [1:0] {CLS_ADD, CLS_EXEC, CLS_BR} cls_t;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011,
                         ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLTU = 3'b110;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10;
  localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
endpackage

// File: rtl/riscv_mc_controller_alu_decoder.sv
// alu_decoder: maps state class and instruction fields to ALUfunc, illegal flag and branch take polarity (BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu)
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  cls_t       cls,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alufunc,
  output logic       illegal,
  output logic       take_inv
);
  logic       rtype, arith, known, ar_bad, br_bad;
  logic [2:0] ar_func, br_func;
  always_comb begin
    ar_func = ALU_ADD;
    ar_bad  = 1'b0;
    case (funct3)
      3'b000:  ar_func = (rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b100:  ar_func = ALU_XOR;
      3'b110:  ar_func = ALU_OR;
      3'b111:  ar_func = ALU_AND;
      3'b010:  ar_func = ALU_SLT;
      3'b011:  ar_func = ALU_SLTU;
      default: ar_bad  = 1'b1;
    endcase
  end
`ifdef BRANCH_EXT_EN
  always_comb begin
    br_func  = ALU_SUB;
    take_inv = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  ;
      3'b001:  take_inv = 1'b1;
      3'b100:  begin br_func = ALU_SLT;  take_inv = 1'b1; end
      3'b101:  br_func = ALU_SLT;
      3'b110:  begin br_func = ALU_SLTU; take_inv = 1'b1; end
      3'b111:  br_func = ALU_SLTU;
      default: br_bad = 1'b1;
    endcase
  end
`else
  assign br_func  = ALU_SUB;
  assign take_inv = 1'b0;
  assign br_bad   = funct3 != 3'b000;
`endif
  assign rtype   = op == OP_R;
  assign arith   = rtype || op == OP_I;
  assign known   = arith || op == OP_LW || op == OP_SW || op == OP_BR || op == OP_JAL;
  assign illegal = !known || (arith && ar_bad) || (op == OP_BR && br_bad);
  assign alufunc = cls == CLS_EXEC ? ar_func : cls == CLS_BR ? br_func : ALU_ADD;
endmodule

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle RV32I subset control FSM (optional BRANCH_EXT_EN enables full branch set)
module riscv_mc_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUfunc,
  output logic       illegal,
  output logic [3:0] state
);
  state_t state_q, state_d;
  cls_t   cls;
  logic   pcw, irw, mw, rw, dec_ill, take_inv;
  alu_decoder u_dec (
    .cls(cls), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .alufunc(ALUfunc), .illegal(dec_ill), .take_inv(take_inv)
  );
  always_ff @(posedge clk)
    state_q <= rst ? FETCH : state_d;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = dec_ill ? FETCH :
                        (op == OP_LW || op == OP_SW) ? MEMADR :
                        op == OP_R ? EXECR : op == OP_I ? EXECI :
                        op == OP_BR ? BRANCH : JAL;
      MEMADR:  state_d = op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD: state_d = MEMWB;
      EXECR, EXECI, JAL: state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    pcw       = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = A_PC;
    ALUSrcB   = B_RS2;
    cls       = CLS_ADD;
    case (state_q)
      FETCH:    begin irw = 1'b1; pcw = 1'b1; ALUSrcB = B_FOUR; ResultSrc = RES_ALURES; end
      DECODE:   begin ALUSrcA = A_OLDPC; ALUSrcB = B_IMM; end
      MEMADR:   begin ALUSrcA = A_RS1; ALUSrcB = B_IMM; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = RES_DATA; rw = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; mw = 1'b1; end
      EXECR:    begin ALUSrcA = A_RS1; cls = CLS_EXEC; end
      EXECI:    begin ALUSrcA = A_RS1; ALUSrcB = B_IMM; cls = CLS_EXEC; end
      ALUWB:    rw = 1'b1;
      BRANCH:   begin ALUSrcA = A_RS1; cls = CLS_BR; pcw = zero ^ take_inv; end
      JAL:      begin ALUSrcA = A_OLDPC; ALUSrcB = B_FOUR; pcw = 1'b1; end
      default:  ;
    endcase
  end
  // reset overrides every strobe so an aborted instruction leaves no side effects
  assign PCWrite  = pcw & ~rst;
  assign IRWrite  = irw & ~rst;
  assign MemWrite = mw & ~rst;
  assign RegWrite = rw & ~rst;
  assign illegal  = state_q == DECODE && dec_ill && !rst;
  assign ImmSrc   = op == OP_SW ? IMM_S : op == OP_BR ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  assign state    = state_q;
endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb_riscv_mc_controller: table-driven instruction sequences plus reset corner cases
module tb_riscv_mc_controller;
  logic       clk = 1'b0, rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0, zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUfunc;
  logic [3:0] state;
  int total = 0, bad = 0;

  riscv_mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUfunc(ALUfunc), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, z;
    logic [19:0] seq;
    int          len;
    logic [2:0]  fn;
    logic        pcw;
    int          ill, rw, mw;
    logic [1:0]  imm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [6:0] o, logic [2:0] f3, logic f7, logic z, logic [19:0] seq,
                              int len, logic [2:0] fn, logic pcw, int ill, int rw, int mw, logic [1:0] imm);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.seq = seq; v.len = len; v.fn = fn;
    v.pcw = pcw; v.ill = ill; v.rw = rw; v.mw = mw; v.imm = imm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [3:0] s;
    int nrw, nmw, nil;
    vecs.push_back(mk(7'b0000011, 3'b010, 0, 0, 20'h01234, 5, 3'b000, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(7'b0100011, 3'b010, 0, 0, 20'h0125F, 4, 3'b000, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(7'b0110011, 3'b000, 0, 0, 20'h0168F, 4, 3'b000, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(7'b0110011, 3'b000, 1, 0, 20'h0168F, 4, 3'b001, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(7'b0010011, 3'b000, 1, 0, 20'h0178F, 4, 3'b000, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(7'b0110011, 3'b100, 0, 0, 20'h0168F, 4, 3'b100, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(7'b0010011, 3'b110, 0, 0, 20'h0178F, 4, 3'b011, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(7'b0110011, 3'b111, 0, 0, 20'h0168F, 4, 3'b010, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(7'b0010011, 3'b010, 0, 0, 20'h0178F, 4, 3'b101, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(7'b0110011, 3'b011, 0, 0, 20'h0168F, 4, 3'b110, 0, 0, 1, 0, 2'b00));
    vecs.push_back(mk(7'b0110011, 3'b001, 0, 0, 20'h01FFF, 2, 3'b000, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(7'b0010011, 3'b101, 0, 0, 20'h01FFF, 2, 3'b000, 0, 1, 0, 0, 2'b00));
    vecs.push_back(mk(7'b1100011, 3'b000, 0, 1, 20'h019FF, 3, 3'b001, 1, 0, 0, 0, 2'b10));
    vecs.push_back(mk(7'b1100011, 3'b000, 0, 0, 20'h019FF, 3, 3'b001, 0, 0, 0, 0, 2'b10));
    vecs.push_back(mk(7'b1101111, 3'b000, 0, 0, 20'h01A8F, 4, 3'b000, 0, 0, 1, 0, 2'b11));
    vecs.push_back(mk(7'b1111111, 3'b000, 0, 0, 20'h01FFF, 2, 3'b000, 0, 1, 0, 0, 2'b00));
`ifdef BRANCH_EXT_EN
    vecs.push_back(mk(7'b1100011, 3'b111, 0, 1, 20'h019FF, 3, 3'b110, 1, 0, 0, 0, 2'b10));
    vecs.push_back(mk(7'b1100011, 3'b001, 0, 0, 20'h019FF, 3, 3'b001, 1, 0, 0, 0, 2'b10));
    vecs.push_back(mk(7'b1100011, 3'b100, 0, 1, 20'h019FF, 3, 3'b101, 0, 0, 0, 0, 2'b10));
`else
    vecs.push_back(mk(7'b1100011, 3'b111, 0, 1, 20'h01FFF, 2, 3'b000, 0, 1, 0, 0, 2'b10));
    vecs.push_back(mk(7'b1100011, 3'b001, 0, 0, 20'h01FFF, 2, 3'b000, 0, 1, 0, 0, 2'b10));
`endif

    repeat (2) step();
    chk("rst state", state, 0);
    chk("rst pcwrite", PCWrite, 0);
    chk("rst irwrite", IRWrite, 0);
    rst = 1'b0;
    #1;
    chk("fetch state", state, 0);
    chk("fetch irwrite", IRWrite, 1);
    chk("fetch pcwrite", PCWrite, 1);
    chk("fetch alusrcb", ALUSrcB, 2'b10);
    chk("fetch resultsrc", ResultSrc, 2'b10);

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
      #1;
      nrw = 0; nmw = 0; nil = 0;
      chk($sformatf("v%0d immsrc", k), ImmSrc, v.imm);
      for (int i = 0; i < v.len; i++) begin
        s = v.seq[19-4*i -: 4];
        chk($sformatf("v%0d c%0d state", k, i), state, s);
        chk($sformatf("v%0d c%0d pcwrite", k, i), PCWrite, (s == 0) || (s == 10) || (s == 9 && v.pcw));
        chk($sformatf("v%0d c%0d irwrite", k, i), IRWrite, s == 0);
        if (s == 6 || s == 7 || s == 9) chk($sformatf("v%0d alufunc", k), ALUfunc, v.fn);
        if (s == 4) chk($sformatf("v%0d memwb resultsrc", k), ResultSrc, 2'b01);
        if (s == 1) chk($sformatf("v%0d decode srcs", k), {ALUSrcA, ALUSrcB}, 4'b0101);
        nrw += int'(RegWrite);
        nmw += int'(MemWrite);
        nil += int'(illegal);
        step();
      end
      chk($sformatf("v%0d end fetch", k), state, 0);
      chk($sformatf("v%0d regwrites", k), nrw, v.rw);
      chk($sformatf("v%0d memwrites", k), nmw, v.mw);
      chk($sformatf("v%0d illegals", k), nil, v.ill);
    end

    op = 7'b0000011; funct3 = 3'b010;
    repeat (3) step();
    chk("abort state memread", state, 3);
    rst = 1'b1;
    #1;
    chk("abort regwrite", RegWrite, 0);
    chk("abort adrsrc still decoded", AdrSrc, 1);
    step();
    chk("abort to fetch", state, 0);
    chk("abort irwrite held", IRWrite, 0);
    chk("abort no regwrite", RegWrite, 0);
    rst = 1'b0;
    #1;
    chk("abort release irwrite", IRWrite, 1);

    op = 7'b1111111;
    step();
    chk("illegal decode state", state, 1);
    chk("illegal before rst", illegal, 1);
    rst = 1'b1;
    #1;
    chk("illegal masked by rst", illegal, 0);
    step();
    rst = 1'b0;
    #1;
    chk("illegal rst fetch", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
